div_ctrl: RTL

Multi-cycle divide sequencer for the execute stage. It accepts DIV/DIVU operands and runs a 32-iteration shift-subtract divide. While the divide is in progress it raises the stall request that the hazard unit consumes as stall_divE. It delivers {HI, LO} to the hilo write path and abandons the operation on an exception flush.

---
 rtl/div_ctrl_pkg.sv | 25 ++
 rtl/div_step.sv | 25 ++
 rtl/div_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
package div_ctrl_pkg;

    // Iterations per non-trivial divide; tied to the 32-bit datapath.
    localparam int unsigned DivCyclesDefault = 32;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivRun  = 2'd1,
        DivDone = 2'd2
    } div_state_e;

    // Magnitude of a 32-bit operand; only treated as signed when en is set.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Two's-complement negate when neg is set.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-divide iteration.
module div_step (
    input  logic [32:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic [31:0] quo_out
);

    logic [33:0] shifted;
    logic [33:0] diff;
    logic        ge;

    // Shift {r, q} left one bit, then subtract the divisor if it fits.
    // Working at 34 bits keeps the borrow visible so divisors with bit 31
    // set compare correctly.
    always_comb begin
        shifted = {rem_in, quo_in[31]};
        diff    = shifted - {2'b00, divisor};
        ge      = ~diff[33];
        rem_out = ge ? diff[32:0] : shifted[32:0];
        quo_out = {quo_in[30:0], ge};
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the execute stage: operand capture,
// 32-step restoring divide, sign fixup, stall request and flush handling.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DivCyclesDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall_div
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV_CYCLES - 1);

    div_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [32:0]     rem_q;
    logic [31:0]     quo_q;
    logic [31:0]     dvs_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            ready_q;

    logic [32:0]     step_rem;
    logic [31:0]     step_quo;
    logic [31:0]     hi_fix;
    logic [31:0]     lo_fix;

    div_step u_div_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Sequencer FSM with operand capture, iteration and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DivIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (annul) begin
                // Flush wins over everything, including a same-cycle start.
                state_q <= DivIdle;
            end else begin
                unique case (state_q)
                    DivIdle: begin
                        if (start) begin
                            if (opb == 32'd0) begin
                                // Divide by zero: raw operands, no sign fixup.
                                rem_q     <= {1'b0, opa};
                                quo_q     <= 32'hFFFF_FFFF;
                                neg_quo_q <= 1'b0;
                                neg_rem_q <= 1'b0;
                                state_q   <= DivDone;
                                ready_q   <= 1'b1;
                            end else begin
                                rem_q     <= '0;
                                quo_q     <= abs_val(opa, signed_div);
                                dvs_q     <= abs_val(opb, signed_div);
                                neg_quo_q <= signed_div & (opa[31] ^ opb[31]);
                                neg_rem_q <= signed_div & opa[31];
                                cnt_q     <= '0;
                                state_q   <= DivRun;
                            end
                        end
                    end
                    DivRun: begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntLast) begin
                            state_q <= DivDone;
                            ready_q <= 1'b1;
                        end
                    end
                    DivDone: begin
                        state_q <= DivIdle;
                    end
                    default: begin
                        state_q <= DivIdle;
                    end
                endcase
            end
        end
    end

    // Sign fixup at the result mux; result is only driven during the ready pulse.
    always_comb begin
        lo_fix = cond_neg(quo_q, neg_quo_q);
        hi_fix = cond_neg(rem_q[31:0], neg_rem_q);
        result = ready_q ? {hi_fix, lo_fix} : 64'd0;
    end

    // Stall while a divide is pending and its result is not yet available.
    always_comb begin
        ready     = ready_q;
        stall_div = start & ~ready_q & ~annul;
    end

endmodule
